// File: rtl/alu_div.sv
// Purpose : radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency : done_o in cycle XLEN+2 after the accepting edge; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: none; start_i is only sampled in IDLE and ignored while busy_o=1 (including the DONE cycle).
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i, alu_op_i   request strobe and operation (one of the four divide ops)
//   a_i, b_i            dividend / divisor, captured on the accepting edge
//   busy_o              high whenever the FSM is not idle
//   done_o              one-cycle pulse; c_o is valid from this cycle
//   c_o                 registered result, held until the next accepted request

package alu_div_pkg;
    localparam logic [4:0] ALU_OP_ADD  = 5'd0;
    localparam logic [4:0] ALU_OP_DIV  = 5'd12;
    localparam logic [4:0] ALU_OP_DIVU = 5'd13;
    localparam logic [4:0] ALU_OP_REM  = 5'd14;
    localparam logic [4:0] ALU_OP_REMU = 5'd15;
endpackage

module alu_div
    import alu_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] c_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            rem_op_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    // Request decode and operand preparation
    logic            op_valid;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_c;

    // One restoring step
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            trial_ok;

    always_comb begin
        op_valid  = (alu_op_i == ALU_OP_DIV)  || (alu_op_i == ALU_OP_DIVU) ||
                    (alu_op_i == ALU_OP_REM)  || (alu_op_i == ALU_OP_REMU);
        op_signed = (alu_op_i == ALU_OP_DIV)  || (alu_op_i == ALU_OP_REM);
        op_rem    = (alu_op_i == ALU_OP_REM)  || (alu_op_i == ALU_OP_REMU);
        a_neg     = op_signed & a_i[XLEN-1];
        b_neg     = op_signed & b_i[XLEN-1];
        // The most negative value negates to itself, which is the correct
        // magnitude when read back as unsigned.
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
        div_zero  = (b_i == '0);
        overflow  = op_signed && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        // Overflow: quotient is the dividend itself (0x80..0), remainder is 0.
        if (div_zero) begin
            special_c = op_rem ? a_i : '1;
        end else begin
            special_c = op_rem ? '0 : a_i;
        end

        // The shifted partial remainder needs one extra bit before the trial
        // subtraction; the trial's MSB is then the borrow.
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        trial_ok = ~trial[XLEN];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            c_o       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i && op_valid) begin
                        rem_op_q  <= op_rem;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_o    <= 1'b1;
                        if (div_zero || overflow) begin
                            c_o     <= special_c;
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (trial_ok) begin
                        rem_q <= trial[XLEN-1:0];
                    end else begin
                        rem_q <= rem_sh[XLEN-1:0];
                    end
                    quo_q <= {quo_q[XLEN-2:0], trial_ok};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    if (rem_op_q) begin
                        c_o <= neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        c_o <= neg_quo_q ? -quo_q : quo_q;
                    end
                    done_o  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Purpose : self-checking bench for alu_div (vector table, corner sequences, random vs. model).
// Latency : checks done_o timing in cycles counted from the accepting edge.
// Backpressure: checks that requests during busy / DONE are ignored.

module tb_alu_div;
    import alu_div_pkg::*;

    logic        clk_i    = 1'b0;
    logic        rst_n_i  = 1'b0;
    logic        start_i  = 1'b0;
    logic [4:0]  alu_op_i = 5'd0;
    logic [31:0] a_i      = 32'd0;
    logic [31:0] b_i      = 32'd0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] c_o;

    alu_div #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .c_o      (c_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V division semantics with plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        bit is_signed;
        bit is_rem;
        int sa;
        int sb;
        is_signed = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
        is_rem    = (op == ALU_OP_REM) || (op == ALU_OP_REMU);
        sa = a;
        sb = b;
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit is_signed;
        is_signed = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
        if (b == 32'd0) return 1;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issues one request and waits for done_o. Returns at the negedge of the
    // done cycle. lat is the cycle number (accepting edge = cycle 0) in which
    // done_o was seen. Operands are scrambled while busy; poke_mid also raises
    // a second start_i mid-calculation.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke_mid, output logic [31:0] res, output int lat,
                          output int busy_bad);
        @(negedge clk_i);
        start_i  = 1'b1;
        alu_op_i = op;
        a_i      = a;
        b_i      = b;
        @(negedge clk_i);
        start_i  = 1'b0;
        a_i      = $urandom;
        b_i      = $urandom;
        lat      = 1;
        busy_bad = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (busy_o !== 1'b1) busy_bad++;
            if (poke_mid && lat == 5) begin
                start_i  = 1'b1;
                alu_op_i = ALU_OP_DIVU;
                a_i      = 32'd77;
                b_i      = 32'd5;
            end
            if (poke_mid && lat == 9) start_i = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        start_i = 1'b0;
        if (busy_o !== 1'b1) busy_bad++;
        res = c_o;
    endtask

    task automatic after_done(input string name, input logic [31:0] exp);
        @(negedge clk_i);
        check({name, " done_drop"}, {31'd0, done_o}, 32'd0);
        check({name, " busy_drop"}, {31'd0, busy_o}, 32'd0);
        check({name, " c_hold"}, c_o, exp);
    endtask

    task automatic run_and_check(input string name, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_c,
                                 input int exp_lat, input bit poke_mid);
        logic [31:0] res;
        int          lat;
        int          busy_bad;
        run_op(op, a, b, poke_mid, res, lat, busy_bad);
        check({name, " result"}, res, exp_c);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy"}, 32'(busy_bad), 32'd0);
        after_done(name, exp_c);
    endtask

    initial begin : main
        logic [31:0] res;
        logic [31:0] prev;
        int          lat;
        int          busy_bad;
        int          dones;

        vecs.push_back('{ALU_OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{ALU_OP_REM,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34});
        vecs.push_back('{ALU_OP_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{ALU_OP_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{ALU_OP_DIVU, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 34});
        vecs.push_back('{ALU_OP_REMU, 32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 34});
        vecs.push_back('{ALU_OP_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{ALU_OP_REM,  32'd5,          32'd0,         32'h0000_0005, 1});
        vecs.push_back('{ALU_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{ALU_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{ALU_OP_DIV,  32'h8000_0000,  32'd1,         32'h8000_0000, 34});
        vecs.push_back('{ALU_OP_REMU, 32'd0,          32'd0,         32'h0000_0000, 1});
        vecs.push_back('{ALU_OP_DIVU, 32'h1234_5678,  32'h1234_5678, 32'h0000_0001, 34});
        vecs.push_back('{ALU_OP_DIVU, 32'd100,        32'd7,         32'h0000_000E, 34});

        // Reset state
        repeat (2) @(negedge clk_i);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset c", c_o, 32'd0);
        rst_n_i = 1'b1;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].c, vecs[i].lat, 1'b0);
        end

        // Non-divide op is ignored
        prev = c_o;
        @(negedge clk_i);
        start_i  = 1'b1;
        alu_op_i = ALU_OP_ADD;
        a_i      = 32'd1;
        b_i      = 32'd2;
        @(negedge clk_i);
        start_i  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("add_ignored busy%0d", k), {31'd0, busy_o}, 32'd0);
            check($sformatf("add_ignored done%0d", k), {31'd0, done_o}, 32'd0);
            check($sformatf("add_ignored c%0d", k), c_o, prev);
            @(negedge clk_i);
        end

        // Second start mid-CALC is ignored
        run_and_check("mid_start", ALU_OP_DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b1);

        // Start during the DONE cycle is ignored
        run_op(ALU_OP_REMU, 32'd1000, 32'd7, 1'b0, res, lat, busy_bad);
        check("done_start result", res, 32'd6);
        start_i  = 1'b1;
        alu_op_i = ALU_OP_DIVU;
        a_i      = 32'd9;
        b_i      = 32'd3;
        @(negedge clk_i);
        start_i  = 1'b0;
        check("done_start busy", {31'd0, busy_o}, 32'd0);
        check("done_start c", c_o, 32'd6);
        @(negedge clk_i);
        check("done_start busy2", {31'd0, busy_o}, 32'd0);

        // Reset mid-operation
        @(negedge clk_i);
        start_i  = 1'b1;
        alu_op_i = ALU_OP_DIVU;
        a_i      = 32'd1000;
        b_i      = 32'd7;
        @(negedge clk_i);
        start_i  = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy_o}, 32'd0);
        check("midrst c", c_o, 32'd0);
        check("midrst done", {31'd0, done_o}, 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dones++;
        end
        rst_n_i = 1'b1;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);
        run_and_check("post_rst", ALU_OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 34, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0:       op = ALU_OP_DIV;
                1:       op = ALU_OP_DIVU;
                2:       op = ALU_OP_REM;
                default: op = ALU_OP_REMU;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(op, a, b, 1'b0, res, lat, busy_bad);
            check($sformatf("rnd%0d op%0d a=%08h b=%08h", i, op, a, b), res, ref_result(op, a, b));
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
            check($sformatf("rnd%0d busy", i), 32'(busy_bad), 32'd0);
            @(negedge clk_i);
            check($sformatf("rnd%0d done_drop", i), {31'd0, done_o}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
